// File: rtl/adat_word_decoder.sv
// ADAT frame decoder: frames on the sync gap, de-nibbles 8 slots into sample words
// and writes them into a circular buffer. Define ADAT_DEC_ERRCNT_EN to enable err_count_o.
module adat_word_decoder #(
  parameter int unsigned CIRC_BUF_BITS = 3,
  parameter int unsigned SAMPLE_BITS   = 24,
  parameter int unsigned SYNC_CONFIRM  = 3,
  parameter int unsigned SYNC_TIMEOUT  = 512
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       adat_bit_i,
  input  logic                       adat_lock_i,
  input  logic                       adat_sync_i,
  input  logic                       smux_i,
  output logic                       ram_write_en_o,
  output logic [CIRC_BUF_BITS+2:0]   ram_write_addr_o,
  output logic [SAMPLE_BITS-1:0]     ram_write_data_o,
  output logic [CIRC_BUF_BITS-1:0]   last_good_frame_idx_o,
  output logic [3:0]                 user_bits_o,
  output logic                       frame_smux_o,
  output logic                       frame_strobe_o,
  output logic                       has_sync_o,
  output logic [15:0]                err_count_o
);

  localparam int unsigned TO_W  = $clog2(SYNC_TIMEOUT + 1);
  localparam int unsigned RUN_W = $clog2(SYNC_CONFIRM + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(SYNC_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(SYNC_CONFIRM - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    WAIT_SYNC,
    USER,
    SAMPLES,
    COMMIT,
    ERROR
  } state_t;

  state_t                   state;
  logic [CIRC_BUF_BITS-1:0] frame_idx;
  logic [RUN_W-1:0]         sync_run;
  logic [TO_W-1:0]          to_cnt;
  logic [2:0]               nib_bit;
  logic [2:0]               nib_idx;
  logic [2:0]               slot;
  logic                     smux_lat;
  logic [3:0]               user_sh;
  logic [22:0]              shreg;

  logic        sync_ok;
  logic        timeout_hit;
  logic        bad_bit;
  logic [23:0] word_next;
  logic [2:0]  slot_addr;

  // sync_run counts how many of the immediately preceding cycles had sync high
  assign sync_ok     = adat_sync_i && (sync_run == RUN_MAX);
  assign timeout_hit = (state == WAIT_SYNC) && adat_lock_i && !sync_ok && (to_cnt == TO_LAST);
  assign bad_bit     = !adat_lock_i || ((nib_bit == 3'd0) && !adat_bit_i);
  assign word_next   = {shreg, adat_bit_i};
  assign slot_addr   = smux_lat ? {slot[0], slot[2:1]} : slot;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state                 <= WAIT_LOCK;
      frame_idx             <= '0;
      sync_run              <= '0;
      to_cnt                <= '0;
      nib_bit               <= '0;
      nib_idx               <= '0;
      slot                  <= '0;
      smux_lat              <= 1'b0;
      user_sh               <= '0;
      shreg                 <= '0;
      ram_write_en_o        <= 1'b0;
      ram_write_addr_o      <= '0;
      ram_write_data_o      <= '0;
      last_good_frame_idx_o <= '0;
      user_bits_o           <= '0;
      frame_smux_o          <= 1'b0;
      frame_strobe_o        <= 1'b0;
      has_sync_o            <= 1'b0;
    end else begin
      ram_write_en_o <= 1'b0;
      frame_strobe_o <= 1'b0;

      if (!adat_sync_i)
        sync_run <= '0;
      else if (sync_run != RUN_MAX)
        sync_run <= sync_run + RUN_W'(1);

      if (state != WAIT_SYNC)
        to_cnt <= '0;

      case (state)
        WAIT_LOCK: begin
          if (adat_lock_i) state <= WAIT_SYNC;
        end

        WAIT_SYNC: begin
          if (!adat_lock_i) begin
            state  <= WAIT_LOCK;
            to_cnt <= '0;
          end else if (sync_ok) begin
            state    <= USER;
            to_cnt   <= '0;
            smux_lat <= smux_i;
            nib_bit  <= '0;
            nib_idx  <= '0;
            slot     <= '0;
          end else if (to_cnt != TO_MAX) begin
            to_cnt <= to_cnt + TO_W'(1);
            if (timeout_hit) has_sync_o <= 1'b0;
          end
        end

        USER: begin
          if (bad_bit) begin
            state <= ERROR;
          end else begin
            if (nib_bit != 3'd0) user_sh <= {adat_bit_i, user_sh[3:1]};
            if (nib_bit == 3'd4) begin
              nib_bit <= '0;
              state   <= SAMPLES;
            end else begin
              nib_bit <= nib_bit + 3'd1;
            end
          end
        end

        SAMPLES: begin
          if (bad_bit) begin
            state <= ERROR;
          end else begin
            if (nib_bit != 3'd0) shreg <= word_next[22:0];
            if (nib_bit == 3'd4) begin
              nib_bit <= '0;
              if (nib_idx == 3'd5) begin
                // last bit of the slot: the full word includes the bit arriving now
                nib_idx          <= '0;
                ram_write_en_o   <= 1'b1;
                ram_write_addr_o <= {frame_idx, slot_addr};
                ram_write_data_o <= word_next[23 -: SAMPLE_BITS];
                slot             <= slot + 3'd1;
                if (slot == 3'd7) state <= COMMIT;
              end else begin
                nib_idx <= nib_idx + 3'd1;
              end
            end else begin
              nib_bit <= nib_bit + 3'd1;
            end
          end
        end

        COMMIT: begin
          last_good_frame_idx_o <= frame_idx;
          frame_idx             <= frame_idx + CIRC_BUF_BITS'(1);
          user_bits_o           <= user_sh;
          frame_smux_o          <= smux_lat;
          frame_strobe_o        <= 1'b1;
          has_sync_o            <= 1'b1;
          state                 <= WAIT_SYNC;
        end

        ERROR: begin
          has_sync_o <= 1'b0;
          state      <= WAIT_LOCK;
        end

        default: state <= WAIT_LOCK;
      endcase
    end
  end

`ifdef ADAT_DEC_ERRCNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      err_cnt <= '0;
    else if (((state == ERROR) || timeout_hit) && (err_cnt != 16'hFFFF))
      err_cnt <= err_cnt + 16'd1;
  end

  assign err_count_o = err_cnt;
`else
  assign err_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_adat_word_decoder.sv
// Bench for adat_word_decoder: table-driven and random frames against a frame-level model,
// plus reset-mid-frame and sync-timeout sequences. A second instance checks SAMPLE_BITS=16.
`timescale 1ns/1ps
module tb_adat_word_decoder;

`ifdef ADAT_DEC_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_i, adat_bit_i, adat_lock_i, adat_sync_i, smux_i;
  logic        ram_write_en_o;
  logic [5:0]  ram_write_addr_o;
  logic [23:0] ram_write_data_o;
  logic [2:0]  last_good_frame_idx_o;
  logic [3:0]  user_bits_o;
  logic        frame_smux_o, frame_strobe_o, has_sync_o;
  logic [15:0] err_count_o;

  logic        w16_en;
  logic [5:0]  w16_addr;
  logic [15:0] w16_data;
  logic [2:0]  w16_last;
  logic [3:0]  w16_user;
  logic        w16_smux, w16_strobe, w16_sync;
  logic [15:0] w16_err;

  adat_word_decoder dut (
    .clk_i(clk_i), .reset_i(reset_i), .adat_bit_i(adat_bit_i), .adat_lock_i(adat_lock_i),
    .adat_sync_i(adat_sync_i), .smux_i(smux_i), .ram_write_en_o(ram_write_en_o),
    .ram_write_addr_o(ram_write_addr_o), .ram_write_data_o(ram_write_data_o),
    .last_good_frame_idx_o(last_good_frame_idx_o), .user_bits_o(user_bits_o),
    .frame_smux_o(frame_smux_o), .frame_strobe_o(frame_strobe_o), .has_sync_o(has_sync_o),
    .err_count_o(err_count_o)
  );

  adat_word_decoder #(.SAMPLE_BITS(16)) dut16 (
    .clk_i(clk_i), .reset_i(reset_i), .adat_bit_i(adat_bit_i), .adat_lock_i(adat_lock_i),
    .adat_sync_i(adat_sync_i), .smux_i(smux_i), .ram_write_en_o(w16_en),
    .ram_write_addr_o(w16_addr), .ram_write_data_o(w16_data),
    .last_good_frame_idx_o(w16_last), .user_bits_o(w16_user),
    .frame_smux_o(w16_smux), .frame_strobe_o(w16_strobe), .has_sync_o(w16_sync),
    .err_count_o(w16_err)
  );

  always #5 clk_i = ~clk_i;

  // kind: 0 good, 1 separator forced 0 (eslot<0 = user separator), 2 lock dropped for 3 bits
  typedef struct {
    logic [3:0] user;
    logic       smux;
    int         pat;
    int         kind;
    int         eslot;
    int         enib;
    int         ebit;
    int         nwr;
    bit         strobe;
  } vec_t;

  typedef struct {
    longint pack;
    int     cyc;
  } wr_t;

  wr_t         wq[$];
  int          cyc = 0;
  int          n_strobe = 0;
  int          strobe_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] samp[8];
  int          fidx = 0;
  int          err_model = 0;
  bit          hs_model = 0;

  function automatic longint pack_wr(input logic [5:0] a, input logic [23:0] d,
                                     input logic [15:0] d16, input logic e16);
    return longint'({a, d, d16, e16});
  endfunction

  always @(posedge clk_i) begin
    #1;
    cyc++;
    if (ram_write_en_o) begin
      wr_t w;
      w.pack = pack_wr(ram_write_addr_o, ram_write_data_o, w16_data, w16_en);
      w.cyc  = cyc;
      wq.push_back(w);
    end
    if (frame_strobe_o) begin
      n_strobe++;
      strobe_cyc = cyc;
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int err_pos(input vec_t v);
    if (v.kind == 1) return (v.eslot < 0) ? 0 : 5 + 30 * v.eslot + 5 * v.enib;
    if (v.kind == 2) return 5 + 30 * v.eslot + 5 * v.enib + v.ebit;
    return 1000;
  endfunction

  // a slot is written only if its last bit arrives before the first bad bit
  function automatic int model_nwr(input vec_t v);
    int n = 0;
    for (int k = 0; k < 8; k++)
      if (5 + 30 * k + 29 < err_pos(v)) n++;
    return n;
  endfunction

  // S/MUX2: slot k carries channel k/2 at time k%2; stored time-major
  function automatic int slot_addr(input int k, input logic smux);
    return smux ? (k % 2) * 4 + k / 2 : k;
  endfunction

  function automatic logic frame_bit(input vec_t v, input int i);
    int j, k, r, nib, b;
    if (i == 0) return !(v.kind == 1 && v.eslot < 0);
    if (i < 5) return v.user[i-1];
    j = i - 5; k = j / 30; r = j % 30; nib = r / 5; b = r % 5;
    if (b == 0) return !(v.kind == 1 && v.eslot == k && v.enib == nib);
    return samp[k][23 - (nib * 4 + b - 1)];
  endfunction

  task automatic fill_samples(input int pat);
    for (int k = 0; k < 8; k++)
      case (pat)
        0:       samp[k] = 24'hA50000 + 24'(k);
        2:       samp[k] = 24'h123456;
        default: samp[k] = 24'($urandom);
      endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      adat_bit_i = 1'b0; adat_lock_i = 1'b1; adat_sync_i = 1'b0;
    end
  endtask

  task automatic send_frame(input vec_t v, input int stop_at);
    int epos;
    epos = err_pos(v);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      adat_bit_i = 1'b0; adat_lock_i = 1'b1; adat_sync_i = (i >= 7); smux_i = v.smux;
    end
    for (int i = 0; i < 245 && i < stop_at; i++) begin
      @(negedge clk_i);
      adat_sync_i = 1'b0;
      adat_bit_i  = frame_bit(v, i);
      adat_lock_i = !(v.kind == 2 && i >= epos && i < epos + 3);
      smux_i      = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic check_frame(input vec_t v, input int exp_nwr, input bit exp_strobe);
    int n;
    idle(3);
    chk("write_count", wq.size(), exp_nwr);
    n = (wq.size() < exp_nwr) ? wq.size() : exp_nwr;
    for (int k = 0; k < n; k++)
      chk($sformatf("write_slot%0d", k), wq[k].pack,
          pack_wr(6'(fidx * 8 + slot_addr(k, v.smux)), samp[k], samp[k][23:8], 1'b1));
    chk("strobe_count", n_strobe, exp_strobe ? 1 : 0);
    if (exp_strobe) begin
      if (wq.size() == 8) chk("strobe_after_slot7", strobe_cyc, wq[7].cyc + 1);
      chk("last_good_idx", last_good_frame_idx_o, fidx);
      chk("user_bits", user_bits_o, v.user);
      chk("frame_smux", frame_smux_o, v.smux);
      fidx = (fidx + 1) % 8;
      hs_model = 1'b1;
    end else begin
      hs_model = 1'b0;
      err_model++;
    end
    chk("has_sync", has_sync_o, hs_model);
    chk("err_count", err_count_o, ERRCNT ? err_model : 0);
    wq.delete();
    n_strobe = 0;
  endtask

  task automatic run_vec(input vec_t v, input int exp_nwr, input bit exp_strobe);
    fill_samples(v.pat);
    wq.delete();
    n_strobe = 0;
    send_frame(v, 245);
    check_frame(v, exp_nwr, exp_strobe);
  endtask

  initial begin
    vec_t tv[10];
    vec_t v;

    tv[0] = '{4'hA, 1'b0, 0, 0,  0, 0, 0, 8, 1'b1};
    tv[1] = '{4'hA, 1'b1, 0, 0,  0, 0, 0, 8, 1'b1};
    tv[2] = '{4'h5, 1'b0, 1, 1,  2, 3, 0, 2, 1'b0};
    tv[3] = '{4'h3, 1'b0, 1, 0,  0, 0, 0, 8, 1'b1};
    tv[4] = '{4'hC, 1'b0, 1, 2,  5, 2, 2, 5, 1'b0};
    tv[5] = '{4'h6, 1'b1, 1, 0,  0, 0, 0, 8, 1'b1};
    tv[6] = '{4'h9, 1'b0, 1, 1,  7, 0, 0, 7, 1'b0};
    tv[7] = '{4'hF, 1'b0, 1, 1, -1, 0, 0, 0, 1'b0};
    tv[8] = '{4'h1, 1'b1, 1, 2,  7, 5, 4, 7, 1'b0};
    tv[9] = '{4'h2, 1'b0, 2, 0,  0, 0, 0, 8, 1'b1};

    reset_i = 1'b1; adat_bit_i = 1'b0; adat_lock_i = 1'b0; adat_sync_i = 1'b0; smux_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("reset_write", {ram_write_en_o, ram_write_addr_o, ram_write_data_o}, 0);
    chk("reset_frame", {last_good_frame_idx_o, user_bits_o, frame_smux_o, frame_strobe_o}, 0);
    chk("reset_sync_err", {has_sync_o, err_count_o}, 0);
    reset_i = 1'b0;
    idle(2);

    for (int t = 0; t < 10; t++)
      run_vec(tv[t], tv[t].nwr, tv[t].strobe);

    for (int t = 0; t < 12; t++) begin
      v.user  = 4'($urandom);
      v.smux  = 1'($urandom_range(0, 1));
      v.pat   = 1;
      v.kind  = $urandom_range(0, 3);
      if (v.kind == 3) v.kind = 0;
      v.eslot = $urandom_range(0, 7);
      v.enib  = $urandom_range(0, 5);
      v.ebit  = $urandom_range(0, 4);
      run_vec(v, model_nwr(v), v.kind == 0);
    end

    // nine good frames in a row: frame index must wrap through 7 back to 0
    for (int t = 0; t < 9; t++) begin
      v.user = 4'($urandom); v.smux = 1'($urandom_range(0, 1)); v.pat = 1;
      v.kind = 0; v.eslot = 0; v.enib = 0; v.ebit = 0;
      run_vec(v, 8, 1'b1);
    end

    // no sync gap: has_sync must hold just short of the timeout and drop after it
    idle(500);
    chk("sync_before_timeout", has_sync_o, 1);
    idle(30);
    chk("sync_after_timeout", has_sync_o, 0);
    hs_model = 1'b0;
    err_model++;
    chk("err_after_timeout", err_count_o, ERRCNT ? err_model : 0);

    // reset arriving on the edge that would complete slot 3
    v.user = 4'h7; v.smux = 1'b0; v.pat = 1; v.kind = 0; v.eslot = 0; v.enib = 0; v.ebit = 0;
    fill_samples(1);
    send_frame(v, 124);
    @(negedge clk_i);
    wq.delete(); n_strobe = 0;
    reset_i = 1'b1; adat_bit_i = frame_bit(v, 124);
    @(negedge clk_i);
    chk("midreset_write", {ram_write_en_o, ram_write_addr_o, ram_write_data_o}, 0);
    chk("midreset_frame", {last_good_frame_idx_o, user_bits_o, frame_smux_o, frame_strobe_o}, 0);
    chk("midreset_sync_err", {has_sync_o, err_count_o}, 0);
    reset_i = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      adat_bit_i = 1'($urandom_range(0, 1)); adat_lock_i = 1'b1; adat_sync_i = 1'b0;
    end
    chk("writes_after_reset", wq.size(), 0);
    chk("strobes_after_reset", n_strobe, 0);
    chk("sync_after_reset", has_sync_o, 0);
    fidx = 0; err_model = 0; hs_model = 1'b0;
    wq.delete(); n_strobe = 0;

    v.user = 4'h4; v.smux = 1'b1; v.pat = 1;
    run_vec(v, 8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
